// File: rtl/mc_control.sv
// mc_control: multi-cycle MIPS control FSM with a memory ready handshake.
// Defining MC_CONTROL_PERF_CNT_EN adds retired-instruction and stall-cycle counters.
module mc_control #(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W = 2,
    parameter logic [OPCODE_W-1:0] OP_RTYPE = 6'h00,
    parameter logic [OPCODE_W-1:0] OP_BEQ = 6'h04,
    parameter logic [OPCODE_W-1:0] OP_BNE = 6'h05,
    parameter logic [OPCODE_W-1:0] OP_LW = 6'h23,
    parameter logic [OPCODE_W-1:0] OP_SW = 6'h2B,
    parameter logic [OPCODE_W-1:0] OP_ADDI = 6'h08,
    parameter logic [OPCODE_W-1:0] OP_J = 6'h02,
    parameter logic [OPCODE_W-1:0] OP_LUI = 6'h0F,
    parameter int CNT_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] instruction,
    input  logic                mem_ready,
    output logic [ALUOP_W-1:0]  ALUOp,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IorD,
    output logic                IRWrite,
    output logic                RegWrite,
    output logic                RegDst,
    output logic                MemtoReg,
    output logic                LUI,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic                BNE,
    output logic [1:0]          PCSource,
    output logic                illegal,
`ifdef MC_CONTROL_PERF_CNT_EN
    output logic [CNT_W-1:0]    instr_retired,
    output logic [CNT_W-1:0]    stall_cycles,
`endif
    output logic [3:0]          state
);
    typedef enum logic [3:0] {
        IDLE = 4'd0, FETCH = 4'd1, DECODE = 4'd2, MEMADR = 4'd3, MEMRD = 4'd4,
        MEMWB = 4'd5, MEMWR = 4'd6, EXEC = 4'd7, RWB = 4'd8, BRANCH = 4'd9,
        IEXEC = 4'd10, IWB = 4'd11, JUMP = 4'd12
    } state_e;

    state_e state_q, state_d;
    logic [OPCODE_W-1:0] op_q;

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:   state_d = mem_ready ? DECODE : FETCH;
            DECODE:  state_d = (instruction == OP_LW || instruction == OP_SW) ? MEMADR :
                               (instruction == OP_RTYPE) ? EXEC :
                               (instruction == OP_BEQ || instruction == OP_BNE) ? BRANCH :
                               (instruction == OP_ADDI || instruction == OP_LUI) ? IEXEC :
                               (instruction == OP_J) ? JUMP : FETCH;
            MEMADR:  state_d = (op_q == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   state_d = mem_ready ? MEMWB : MEMRD;
            MEMWR:   state_d = mem_ready ? FETCH : MEMWR;
            EXEC:    state_d = RWB;
            IEXEC:   state_d = IWB;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == DECODE) op_q <= instruction;
        end
    end

    always_comb begin
        ALUOp       = '0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IorD        = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        LUI         = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        BNE         = 1'b0;
        PCSource    = 2'b00;
        illegal     = 1'b0;
        case (state_q)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                ALUOp   = ALUOP_W'(2'b10);
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                ALUOp   = ALUOP_W'(2'b10);
                illegal = !(instruction inside {OP_RTYPE, OP_BEQ, OP_BNE, OP_LW,
                                                OP_SW, OP_ADDI, OP_J, OP_LUI});
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = ALUOP_W'(2'b10);
            end
            MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            EXEC: ALUSrcA = 1'b1;
            RWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALUOP_W'(2'b01);
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                BNE         = (op_q == OP_BNE);
            end
            IEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = ALUOP_W'(2'b10);
                LUI     = (op_q == OP_LUI);
            end
            IWB: begin
                RegWrite = 1'b1;
                LUI      = (op_q == OP_LUI);
            end
            JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                ALUOp    = ALUOP_W'(2'b11);
            end
            default: ;
        endcase
    end

    assign state = state_q;

`ifdef MC_CONTROL_PERF_CNT_EN
    logic [CNT_W-1:0] instr_retired_q, stall_cycles_q;
    logic retire, stall;

    // An illegal opcode returns to FETCH from DECODE and is not counted as retired.
    assign retire = (state_q inside {MEMWB, RWB, BRANCH, IWB, JUMP}) || (state_q == MEMWR && mem_ready);
    assign stall  = (state_q inside {FETCH, MEMRD, MEMWR}) && !mem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_retired_q <= '0;
            stall_cycles_q  <= '0;
        end else begin
            instr_retired_q <= instr_retired_q + CNT_W'(retire);
            stall_cycles_q  <= stall_cycles_q + CNT_W'(stall);
        end
    end

    assign instr_retired = instr_retired_q;
    assign stall_cycles  = stall_cycles_q;
`endif
endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: directed bench; per-instruction step lists expand into an expected per-cycle trace.
module tb_mc_control;
    localparam logic [5:0] L_R = 6'h00, L_BEQ = 6'h04, L_BNE = 6'h05, L_LW = 6'h23;
    localparam logic [5:0] L_SW = 6'h2B, L_ADDI = 6'h08, L_J = 6'h02, L_LUI = 6'h0F;

    logic clk = 1'b0, rst_n = 1'b0, mem_ready = 1'b0;
    logic [5:0] instruction = 6'h3F;
    logic [1:0] ALUOp, ALUSrcB, PCSource;
    logic ALUSrcA, MemRead, MemWrite, IorD, IRWrite, RegWrite, RegDst, MemtoReg;
    logic LUI, PCWrite, PCWriteCond, BNE, illegal;
    logic [3:0] state;
`ifdef MC_CONTROL_PERF_CNT_EN
    logic [31:0] instr_retired, stall_cycles;
`endif
    logic [18:0] dut_out;

    mc_control dut (
        .clk(clk), .rst_n(rst_n), .instruction(instruction), .mem_ready(mem_ready),
        .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .MemRead(MemRead),
        .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .LUI(LUI), .PCWrite(PCWrite),
        .PCWriteCond(PCWriteCond), .BNE(BNE), .PCSource(PCSource), .illegal(illegal),
`ifdef MC_CONTROL_PERF_CNT_EN
        .instr_retired(instr_retired), .stall_cycles(stall_cycles),
`endif
        .state(state)
    );

    always #5 clk = ~clk;

    assign dut_out = {ALUOp, ALUSrcA, ALUSrcB, MemRead, MemWrite, IorD, IRWrite, RegWrite,
                      RegDst, MemtoReg, LUI, PCWrite, PCWriteCond, BNE, PCSource, illegal};

    typedef struct { int st; logic mr; logic [5:0] op; } rec_t;
    rec_t q[$];
    rec_t cur;
    bit chk = 0;
    int n_chk = 0, n_fail = 0, cyc = 0;
    int n_memrd = 0, n_bne = 0, n_lui = 0, n_ill = 0;
    int exp_ret = 0, exp_stall = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Required control word for a state number, opcode and mem_ready, straight from the state table.
    function automatic logic [18:0] exp_out(int st, logic [5:0] op, logic mr);
        logic [1:0] aop, srcb, pcs;
        logic srca, mrd, mwr, iord, irw, rw, rd, m2r, lui, pcw, pcwc, bne, ill;
        {aop, srcb, pcs, srca, mrd, mwr, iord, irw, rw, rd, m2r, lui, pcw, pcwc, bne, ill} = '0;
        case (st)
            1:  begin mrd = 1; srcb = 2'b01; aop = 2'b10; irw = mr; pcw = mr; end
            2:  begin srcb = 2'b11; aop = 2'b10;
                      ill = !(op inside {L_R, L_BEQ, L_BNE, L_LW, L_SW, L_ADDI, L_J, L_LUI}); end
            3:  begin srca = 1; srcb = 2'b10; aop = 2'b10; end
            4:  begin mrd = 1; iord = 1; end
            5:  begin rw = 1; m2r = 1; end
            6:  begin mwr = 1; iord = 1; end
            7:  srca = 1;
            8:  begin rw = 1; rd = 1; end
            9:  begin srca = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; bne = (op == L_BNE); end
            10: begin srca = 1; srcb = 2'b10; aop = 2'b10; lui = (op == L_LUI); end
            11: begin rw = 1; lui = (op == L_LUI); end
            12: begin pcw = 1; pcs = 2'b10; aop = 2'b11; end
            default: ;
        endcase
        return {aop, srca, srcb, mrd, mwr, iord, irw, rw, rd, m2r, lui, pcw, pcwc, bne, pcs, ill};
    endfunction

    task automatic push(int st, logic [5:0] op);
        q.push_back('{st: st, mr: 1'b0, op: op});
    endtask

    task automatic push_wait(int st, logic [5:0] op, int waits);
        for (int i = 0; i < waits; i++) q.push_back('{st: st, mr: 1'b0, op: op});
        q.push_back('{st: st, mr: 1'b1, op: op});
    endtask

    task automatic add_instr(logic [5:0] op, int wf, int wm);
        push_wait(1, op, wf);
        push(2, op);
        case (op)
            L_LW:          begin push(3, op); push_wait(4, op, wm); push(5, op); end
            L_SW:          begin push(3, op); push_wait(6, op, wm); end
            L_R:           begin push(7, op); push(8, op); end
            L_BEQ, L_BNE:  push(9, op);
            L_ADDI, L_LUI: begin push(10, op); push(11, op); end
            L_J:           push(12, op);
            default: ;
        endcase
        if (op inside {L_R, L_BEQ, L_BNE, L_LW, L_SW, L_ADDI, L_J, L_LUI}) exp_ret++;
        exp_stall += wf + wm;
    endtask

    // Instruction is scrambled outside DECODE to show it is ignored there.
    task automatic play(int n);
        for (int i = 0; i < n && q.size() > 0; i++) begin
            @(posedge clk);
            #1;
            cur = q.pop_front();
            mem_ready = cur.mr;
            instruction = (cur.st == 2) ? cur.op : ~cur.op;
            chk = 1;
            @(negedge clk);
            #1;
        end
        chk = 0;
    endtask

    always @(negedge clk) begin
        if (chk) begin
            cyc++;
            check($sformatf("state cyc%0d", cyc), 32'(state), 32'(cur.st));
            check($sformatf("outputs cyc%0d st%0d", cyc, cur.st), 32'(dut_out), 32'(exp_out(cur.st, cur.op, cur.mr)));
            if (state == 4'd4) n_memrd++;
            if (BNE) n_bne++;
            if (LUI) n_lui++;
            if (illegal) n_ill++;
        end
    end

    initial begin
        int sz;
        repeat (2) @(negedge clk);
        #1;
        check("reset state", 32'(state), 32'd0);
        check("reset outputs", 32'(dut_out), 32'd0);
        check("model pin bne branch", 32'(exp_out(9, L_BNE, 1'b0)), 32'b0110000000000011010);
        rst_n = 1'b1;
        add_instr(L_R, 0, 0);
        sz = q.size();
        add_instr(L_LW, 0, 2);
        check("lw cycle count", 32'(q.size() - sz), 32'd7);
        add_instr(L_BNE, 0, 0);
        add_instr(L_BEQ, 0, 0);
        add_instr(L_LUI, 0, 0);
        add_instr(L_J, 0, 0);
        add_instr(L_ADDI, 1, 0);
        add_instr(L_SW, 1, 1);
        add_instr(6'h3F, 0, 0);
        add_instr(L_R, 0, 0);
        play(q.size());
        check("memrd cycles", 32'(n_memrd), 32'd3);
        check("bne high cycles", 32'(n_bne), 32'd1);
        check("lui high cycles", 32'(n_lui), 32'd2);
        check("illegal pulses", 32'(n_ill), 32'd1);

        rst_n = 1'b0;
        #1;
        check("reset reentry state", 32'(state), 32'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        add_instr(L_SW, 0, 3);
        play(5);
        rst_n = 1'b0;
        #1;
        check("async reset in memwr state", 32'(state), 32'd0);
        check("async reset in memwr outputs", 32'(dut_out), 32'd0);
        q.delete();
        @(posedge clk);
        #1;
        check("held in idle", 32'(state), 32'd0);
`ifdef MC_CONTROL_PERF_CNT_EN
        check("retired after reset", instr_retired, 32'd0);
        check("stalls after reset", stall_cycles, 32'd0);
`endif
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        exp_ret = 0;
        exp_stall = 0;
        add_instr(L_R, 1, 0);
        add_instr(L_BEQ, 1, 0);
        add_instr(L_SW, 0, 2);
        play(q.size());
        @(posedge clk);
        #1;
        check("back in fetch", 32'(state), 32'd1);
`ifdef MC_CONTROL_PERF_CNT_EN
        check("instr_retired model", instr_retired, 32'(exp_ret));
        check("stall_cycles model", stall_cycles, 32'(exp_stall));
        check("instr_retired literal", instr_retired, 32'd3);
        check("stall_cycles literal", stall_cycles, 32'd4);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
